// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for the sequential divider
interface seq_divider_if #(
    parameter int width = 5
);
    logic [width-1:0] X;
    logic [width-1:0] Y;
    logic             Go;
    logic             Busy;
    logic             Done;
    logic [width-1:0] Q;
    logic [width-1:0] R;
    logic             DivZero;

    modport master (
        output X, Y, Go,
        input  Busy, Done, Q, R, DivZero
    );

    modport slave (
        input  X, Y, Go,
        output Busy, Done, Q, R, DivZero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int width = 5
) (
    input  logic         clock,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int cnt_w = (width > 2) ? $clog2(width) : 1;

    typedef enum logic [1:0] {
        S_idle = 2'd0,
        S_Div  = 2'd1,
        S_Done = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // dq starts as the dividend; quotient bits shift in at the LSB as dividend bits leave the MSB
    logic [width-1:0] dq;
    logic [width-1:0] divisor;
    logic [width-1:0] rem;
    logic [cnt_w-1:0] cnt;

    logic [width:0]   rem_shift;
    logic [width:0]   rem_diff;
    logic             q_bit;
    logic [width-1:0] rem_step;

    // One restoring step: the borrow out of the width+1 bit subtract decides the quotient bit
    always_comb begin
        rem_shift = {rem, dq[width-1]};
        rem_diff  = rem_shift - {1'b0, divisor};
        q_bit     = ~rem_diff[width];
        rem_step  = q_bit ? rem_diff[width-1:0] : rem_shift[width-1:0];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        bus.Busy   = 1'b0;
        bus.Done   = 1'b0;
        case (state)
            S_idle: begin
                if (bus.Go) begin
                    state_next = (bus.Y == '0) ? S_Done : S_Div;
                end
            end
            S_Div: begin
                bus.Busy = 1'b1;
                if (cnt == '0) begin
                    state_next = S_Done;
                end
            end
            S_Done: begin
                bus.Busy   = 1'b1;
                bus.Done   = 1'b1;
                state_next = S_idle;
            end
            default: begin
                state_next = S_idle;
            end
        endcase
    end

    // Datapath and result registers; results only change on the edge entering S_Done
    always_ff @(posedge clock) begin
        if (reset) begin
            dq          <= '0;
            divisor     <= '0;
            rem         <= '0;
            cnt         <= '0;
            bus.Q       <= '0;
            bus.R       <= '0;
            bus.DivZero <= 1'b0;
        end else begin
            case (state)
                S_idle: begin
                    if (bus.Go) begin
                        if (bus.Y == '0) begin
                            bus.Q       <= '1;
                            bus.R       <= bus.X;
                            bus.DivZero <= 1'b1;
                        end else begin
                            dq      <= bus.X;
                            divisor <= bus.Y;
                            rem     <= '0;
                            cnt     <= cnt_w'(width - 1);
                        end
                    end
                end
                S_Div: begin
                    dq  <= {dq[width-2:0], q_bit};
                    rem <= rem_step;
                    if (cnt == '0) begin
                        bus.Q       <= {dq[width-2:0], q_bit};
                        bus.R       <= rem_step;
                        bus.DivZero <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with directed and exhaustive vectors
module tb_seq_divider;
    localparam int W = 5;

    logic clock;
    logic reset;

    seq_divider_if #(.width(W)) bus ();

    seq_divider #(.width(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    int   dones    = 0;
    logic prev_done = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int q, input int r, input int dz);
        exp_t e;
        e.q  = W'(q);
        e.r  = W'(r);
        e.dz = dz[0];
        exp_q.push_back(e);
        accepted++;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses Done
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.Done) begin
                exp_t e;
                dones++;
                if (prev_done) check("done_single_cycle", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("Q", bus.Q, e.q);
                    check("R", bus.R, e.r);
                    check("DivZero", bus.DivZero, e.dz);
                end
            end
            prev_done = bus.Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (bus.Busy) check("wait_idle_timeout", 1, 0);
    endtask

    // Issue one Go from idle; returns at the first negedge after acceptance (cycle 1)
    task automatic start(input int x, input int y, input int q, input int r, input int dz);
        wait_idle();
        bus.X  = W'(x);
        bus.Y  = W'(y);
        bus.Go = 1'b1;
        push_exp(q, r, dz);
        @(negedge clock);
        bus.Go = 1'b0;
    endtask

    // Count cycles from cycle 1 until Done is seen
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.Done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!bus.Done) check("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset  = 1'b1;
        bus.Go = 1'b0;
        bus.X  = '0;
        bus.Y  = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_q", bus.Q, 0);
        check("rst_r", bus.R, 0);
        check("rst_divzero", bus.DivZero, 0);
        reset = 1'b0;
        @(negedge clock);

        // T1: latency and Busy profile
        start(27, 4, 6, 3, 0);
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("t1_busy_c%0d", c), bus.Busy, 1);
            check($sformatf("t1_done_c%0d", c), bus.Done, (c == 6) ? 1 : 0);
            if (c < 6) @(negedge clock);
        end
        @(negedge clock);
        check("t1_busy_after", bus.Busy, 0);
        check("t1_done_after", bus.Done, 0);
        check("t1_q_hold", bus.Q, 6);
        check("t1_r_hold", bus.R, 3);

        // T2: boundary operands
        start(31, 1, 31, 0, 0);
        wait_done(n);
        check("t2a_latency", n, 6);
        @(negedge clock);
        start(3, 7, 0, 3, 0);
        wait_done(n);
        @(negedge clock);
        start(0, 5, 0, 0, 0);
        wait_done(n);
        @(negedge clock);

        // T3: divide by zero, then a normal op clears DivZero
        start(13, 0, 31, 13, 1);
        check("t3_dz_latency", bus.Done, 1);
        @(negedge clock);
        check("t3_busy_after", bus.Busy, 0);
        check("t3_dz_hold", bus.DivZero, 1);
        start(10, 3, 3, 1, 0);
        wait_done(n);
        check("t3b_latency", n, 6);
        @(negedge clock);

        // T4: Go during Busy ignored; held Go restarts right after Done
        start(20, 6, 3, 2, 0);
        @(negedge clock);
        bus.X  = 5'd9;
        bus.Y  = 5'd2;
        bus.Go = 1'b1;
        n = 2;
        while (bus.Busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("t4_idle_cycle", n, 7);
        push_exp(4, 1, 0);
        @(negedge clock);
        bus.Go = 1'b0;
        check("t4_restart_busy", bus.Busy, 1);
        wait_done(n);
        check("t4_second_latency", n, 6);
        @(negedge clock);

        // T5: reset aborts an op in flight without a Done
        start(25, 5, 5, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        void'(exp_q.pop_back());
        accepted--;
        check("t5_busy", bus.Busy, 0);
        check("t5_done", bus.Done, 0);
        check("t5_q", bus.Q, 0);
        check("t5_r", bus.R, 0);
        check("t5_divzero", bus.DivZero, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        start(25, 5, 5, 0, 0);
        wait_done(n);
        check("t5_latency", n, 6);
        @(negedge clock);

        // T6: exhaustive sweep
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 32; y++) begin
                if (y == 0) start(x, y, 31, x, 1);
                else        start(x, y, x / y, x % y, 0);
            end
        end
        wait_idle();
        repeat (3) @(negedge clock);

        check("done_count", dones, accepted);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
